// File: rtl/fp_mult_sched.sv
// Round-robin two-requester front end for the shared multi-cycle FP32 multiplier core.
// Accepts one operand pair, loads the core, waits out its latency and returns a tagged response.
module fp_mult_sched #(
    parameter int unsigned MULT_CYCLES = 26,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_result,
    output logic             resp_overflow,
    output logic             resp_underflow,

    output logic             core_load,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    input  logic [31:0]      core_result,
    input  logic             core_overflow,
    input  logic             core_underflow,

    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned OP_W    = 32;
    localparam int unsigned OPCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [TAG_W-1:0]  tag_q;
    logic              id_q;

    logic              gnt_id;
    logic              accept;
    logic              capture;
    logic              resp_fire;

    // Next-state, grant and handshake decode
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        gnt_id     = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        resp_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                // Contention goes to whoever did not win last time
                if (req0_valid && req1_valid) begin
                    gnt_id = ~last_gnt_q;
                end else begin
                    gnt_id = req1_valid;
                end
                req0_ready = req0_valid && !gnt_id;
                req1_ready = req1_valid && gnt_id;
                accept     = req0_valid || req1_valid;
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            core_load  <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            resp_valid <= (state_d == RESP);
            core_load  <= (state_d == LOAD);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_gnt_q     <= 1'b1;
            cnt_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            tag_q          <= '0;
            id_q           <= 1'b0;
            resp_id        <= 1'b0;
            resp_tag       <= '0;
            resp_result    <= '0;
            resp_overflow  <= 1'b0;
            resp_underflow <= 1'b0;
            op_count       <= '0;
        end else begin
            if (accept) begin
                a_q        <= gnt_id ? req1_a : req0_a;
                b_q        <= gnt_id ? req1_b : req0_b;
                tag_q      <= gnt_id ? req1_tag : req0_tag;
                id_q       <= gnt_id;
                last_gnt_q <= gnt_id;
            end
            if (state_q == LOAD) begin
                cnt_q <= CNT_W'(MULT_CYCLES - 1);
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                resp_id        <= id_q;
                resp_tag       <= tag_q;
                resp_result    <= core_result;
                resp_overflow  <= core_overflow;
                resp_underflow <= core_underflow;
            end
            if (resp_fire) begin
                op_count <= op_count + OPCNT_W'(1);
            end
        end
    end

    assign core_a = a_q;
    assign core_b = b_q;

endmodule

// File: tb/tb_fp_mult_sched.sv
// Bench for fp_mult_sched: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level timing model.
module tb_fp_mult_sched;

    localparam int unsigned MULT  = 26;
    localparam int unsigned TAG_W = 4;
    localparam logic [31:0] FIXED_PRODUCT = 32'h40C00000;

    logic             CLK;
    logic             RST;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             resp_valid, resp_ready, resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_result;
    logic             resp_overflow, resp_underflow;
    logic             core_load;
    logic [31:0]      core_a, core_b, core_result;
    logic             core_overflow, core_underflow;
    logic             busy;
    logic [15:0]      op_count;

    int unsigned cyc = 0;
    bit          core_fixed = 1'b0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int          gnt_log[$];
    logic [31:0] last_resp_result = '0;

    // Reference model state: the scheduler as a single server with timestamps
    bit          m_free;
    bit          m_last;
    int unsigned m_acc_cyc;
    int unsigned m_resp_at;
    logic [31:0] m_a, m_b;
    logic [TAG_W-1:0] m_tag;
    logic        m_id;
    logic [15:0] m_count;

    fp_mult_sched #(.MULT_CYCLES(MULT), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_tag(resp_tag),
        .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_underflow(resp_underflow),
        .core_load(core_load), .core_a(core_a), .core_b(core_b), .core_result(core_result),
        .core_overflow(core_overflow), .core_underflow(core_underflow),
        .busy(busy), .op_count(op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stand-in core: output depends on operands and on the current cycle, so only
    // a capture in exactly the right cycle reproduces the expected value and flags.
    function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned c, input bit fixed);
        logic [31:0] h;
        if (fixed) return {2'b00, FIXED_PRODUCT};
        h = 32'(c * 32'h9E3779B1);
        return {h[31], h[30], (a ^ {b[15:0], b[31:16]}) ^ h};
    endfunction

    assign {core_overflow, core_underflow, core_result} = core_fn(core_a, core_b, cyc, core_fixed);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_free  = 1'b1;
        m_last  = 1'b1;
        m_count = '0;
    endtask

    task automatic raise(input int r);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_tag = TAG_W'($urandom);
        end else begin
            req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_tag = TAG_W'($urandom);
        end
    endtask

    // One clock cycle: check every output against the model, advance the model,
    // cross the edge and retire whichever request was accepted.
    task automatic do_cycle();
        bit e_r0, e_r1, e_rv;
        logic [33:0] e_core;
        #1;
        e_r0 = m_free && (req0_valid === 1'b1) && (req1_valid !== 1'b1 || m_last);
        e_r1 = m_free && (req1_valid === 1'b1) && (req0_valid !== 1'b1 || !m_last);
        e_rv = !m_free && (cyc >= m_resp_at);
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("busy", 32'(busy), 32'(!m_free));
        chk("core_load", 32'(core_load), 32'(!m_free && cyc == m_acc_cyc + 1));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("op_count", 32'(op_count), 32'(m_count));
        if (!m_free) begin
            chk("core_a", core_a, m_a);
            chk("core_b", core_b, m_b);
        end
        if (e_rv) begin
            e_core = core_fn(m_a, m_b, m_acc_cyc + 1 + MULT, core_fixed);
            chk("resp_id", 32'(resp_id), 32'(m_id));
            chk("resp_tag", 32'(resp_tag), 32'(m_tag));
            chk("resp_result", resp_result, e_core[31:0]);
            chk("resp_overflow", 32'(resp_overflow), 32'(e_core[33]));
            chk("resp_underflow", 32'(resp_underflow), 32'(e_core[32]));
            if (resp_ready) last_resp_result = resp_result;
        end
        if (req0_ready === 1'b1) gnt_log.push_back(0);
        else if (req1_ready === 1'b1) gnt_log.push_back(1);

        if (e_r0 || e_r1) begin
            m_free    = 1'b0;
            m_acc_cyc = cyc;
            m_resp_at = cyc + 2 + MULT;
            m_id      = e_r1;
            m_a       = e_r1 ? req1_a : req0_a;
            m_b       = e_r1 ? req1_b : req0_b;
            m_tag     = e_r1 ? req1_tag : req0_tag;
            m_last    = e_r1;
        end else if (e_rv && resp_ready) begin
            m_free  = 1'b1;
            m_count = m_count + 16'd1;
        end
        @(posedge CLK);
        #1;
        if (e_r0) req0_valid = 1'b0;
        if (e_r1) req1_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int unsigned max);
        int unsigned n;
        n = 0;
        do begin
            do_cycle();
            n++;
        end while ((req0_valid || req1_valid || !m_free) && n < max);
        chk("drain_done", 32'(req0_valid || req1_valid || !m_free), 32'd0);
    endtask

    initial begin
        int unsigned n;
        int g0;
        logic [31:0] snap_r;
        logic [TAG_W-1:0] snap_t;
        logic snap_id;

        RST = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
        m_reset();
        m_acc_cyc = 0; m_resp_at = 0; m_a = '0; m_b = '0; m_tag = '0; m_id = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_core_load", 32'(core_load), 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_tag", 32'(resp_tag), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        RST = 1'b0;

        // Single op with a fixed core product
        core_fixed = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000; req0_tag = 4'd5;
        run_until_idle(80);
        chk("single_result", last_resp_result, FIXED_PRODUCT);
        chk("single_op_count", 32'(op_count), 32'd1);
        core_fixed = 1'b0;

        // Starvation: req0 always valid, req1 raised once mid-operation
        gnt_log.delete();
        raise(0);
        n = 0;
        while (gnt_log.size() < 1 && n < 50) begin do_cycle(); n++; end
        raise(1);
        while (gnt_log.size() < 2 && n < 150) begin
            do_cycle();
            if (!req0_valid) raise(0);
            n++;
        end
        chk("starve_winner", 32'(gnt_log[1]), 32'd1);
        run_until_idle(100);

        // Backpressure with both requesters pending
        resp_ready = 1'b0;
        raise(0); raise(1);
        n = 0;
        while (resp_valid !== 1'b1 && n < 80) begin do_cycle(); n++; end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        snap_r = resp_result; snap_t = resp_tag; snap_id = resp_id;
        g0 = gnt_log.size();
        repeat (10) do_cycle();
        chk("bp_result_stable", resp_result, snap_r);
        chk("bp_tag_stable", 32'(resp_tag), 32'(snap_t));
        chk("bp_id_stable", 32'(resp_id), 32'(snap_id));
        chk("bp_no_grant", 32'(gnt_log.size()), 32'(g0));
        resp_ready = 1'b1;
        do_cycle();
        g0 = gnt_log.size();
        do_cycle();
        chk("bp_next_accept", 32'(gnt_log.size()), 32'(g0 + 1));
        run_until_idle(100);

        // Asynchronous reset in the middle of BUSY
        raise(0);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin do_cycle(); n++; end
        repeat (10) do_cycle();
        #3;
        RST = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_core_load", 32'(core_load), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        m_reset();
        @(posedge CLK);
        #4;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Arbitration after reset: 0 then 1, and again 0 then 1
        gnt_log.delete();
        raise(0); raise(1);
        run_until_idle(100);
        raise(0); raise(1);
        run_until_idle(100);
        chk("arb_first", 32'(gnt_log[0]), 32'd0);
        chk("arb_second", 32'(gnt_log[1]), 32'd1);
        chk("arb_third", 32'(gnt_log[2]), 32'd0);
        chk("arb_fourth", 32'(gnt_log[3]), 32'd1);
        chk("arb_op_count", 32'(op_count), 32'd4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!req0_valid && $urandom_range(99) < 30) raise(0);
            if (!req1_valid && $urandom_range(99) < 30) raise(1);
            resp_ready = ($urandom_range(99) < 75);
            do_cycle();
        end
        resp_ready = 1'b1;
        run_until_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
